// File: rtl/mem_io_bridge_if.sv
// Bus bundle between the Minisys datapath side and the memory / IO side of mem_io_bridge.
// The slave modport is the bridge itself; master is whoever drives the datapath inputs.
interface mem_io_bridge_if #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int IO_DATA_W = 24,
    parameter int N_IO      = 4
);
    logic                      mRead;
    logic                      mWrite;
    logic                      ioRead;
    logic                      ioWrite;
    logic [ADDR_W-1:0]         addr_in;
    logic [DATA_W-1:0]         r_rdata;
    logic [DATA_W-1:0]         m_rdata;
    logic [N_IO*IO_DATA_W-1:0] io_rdata;
    logic [N_IO-1:0]           io_ready;

    logic [ADDR_W-1:0]         addr_out;
    logic                      mem_we;
    logic [DATA_W-1:0]         data_to_dmem;
    logic [N_IO-1:0]           io_cs;
    logic                      io_rd;
    logic                      io_wr;
    logic [IO_DATA_W-1:0]      io_wdata;
    logic [DATA_W-1:0]         r_wdata;
    logic                      stall;
    logic                      io_err;

    modport slave (
        input  mRead, mWrite, ioRead, ioWrite, addr_in, r_rdata, m_rdata, io_rdata, io_ready,
        output addr_out, mem_we, data_to_dmem, io_cs, io_rd, io_wr, io_wdata, r_wdata, stall, io_err
    );

    modport master (
        output mRead, mWrite, ioRead, ioWrite, addr_in, r_rdata, m_rdata, io_rdata, io_ready,
        input  addr_out, mem_we, data_to_dmem, io_cs, io_rd, io_wr, io_wdata, r_wdata, stall, io_err
    );
endinterface

// File: rtl/mem_io_bridge.sv
// Minisys memory/IO bridge: memory accesses pass straight through, IO accesses run a
// one-hot select + ready/timeout handshake that stalls the pipeline until completion.
module mem_io_bridge #(
    parameter int                ADDR_W    = 32,
    parameter int                DATA_W    = 32,
    parameter int                IO_DATA_W = 24,
    parameter int                N_IO      = 4,
    parameter logic [ADDR_W-1:0] IO_BASE   = 32'hFFFF_FC00,
    parameter int                CH_SHIFT  = 4,
    parameter int                TIMEOUT   = 15
) (
    input  logic          clock,
    input  logic          reset,
    mem_io_bridge_if.slave bus
);
    localparam int CH_W  = (N_IO > 1) ? $clog2(N_IO) : 1;
    localparam int CNT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t               state;
    logic [CNT_W-1:0]     cnt;
    logic [CH_W-1:0]      ch_q;
    logic                 is_read;
    logic [IO_DATA_W-1:0] cap;
    logic [IO_DATA_W-1:0] wdata;
    logic [N_IO-1:0]      cs;
    logic                 rd;
    logic                 wr;
    logic                 err;

    logic                 io_req;
    logic                 mapped;
    logic [ADDR_W-1:0]    offset;
    logic [CH_W-1:0]      ch;
    logic                 ready_hit;
    logic [IO_DATA_W-1:0] slice;

    assign io_req    = bus.ioRead | bus.ioWrite;
    assign offset    = bus.addr_in - IO_BASE;
    assign mapped    = (bus.addr_in >= IO_BASE) && ((offset >> CH_SHIFT) < ADDR_W'(N_IO));
    assign ch        = offset[CH_SHIFT +: CH_W];
    assign ready_hit = bus.io_ready[ch_q];
    assign slice     = bus.io_rdata[int'(ch_q) * IO_DATA_W +: IO_DATA_W];

    assign bus.addr_out     = bus.addr_in;
    assign bus.data_to_dmem = bus.r_rdata;
    assign bus.mem_we       = (state == IDLE) & bus.mWrite & ~io_req;
    assign bus.stall        = ((state == IDLE) & io_req) | (state == WAIT);
    assign bus.io_cs        = cs;
    assign bus.io_rd        = rd;
    assign bus.io_wr        = wr;
    assign bus.io_wdata     = wdata;
    assign bus.io_err       = err;

    always_comb begin
        bus.r_wdata = '0;
        case (state)
            IDLE:    bus.r_wdata = bus.mRead ? bus.m_rdata : '0;
            DONE:    bus.r_wdata = is_read ? DATA_W'(cap) : '0;
            default: bus.r_wdata = '0;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state   <= IDLE;
            cnt     <= '0;
            ch_q    <= '0;
            is_read <= 1'b0;
            cap     <= '0;
            wdata   <= '0;
            cs      <= '0;
            rd      <= 1'b0;
            wr      <= 1'b0;
            err     <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (io_req) begin
                        ch_q    <= ch;
                        is_read <= bus.ioRead;
                        wdata   <= bus.r_rdata[IO_DATA_W-1:0];
                        cap     <= '0;
                        cnt     <= '0;
                        if (mapped) begin
                            state <= WAIT;
                            cs    <= N_IO'(1) << ch;
                            rd    <= bus.ioRead;
                            wr    <= ~bus.ioRead;
                        end else begin
                            // unmapped channel never touches the IO bus, just reports the error
                            state <= DONE;
                            err   <= 1'b1;
                        end
                    end
                end
                WAIT: begin
                    cnt <= cnt + 1'b1;
                    if (ready_hit) begin
                        if (is_read) cap <= slice;
                        state <= DONE;
                        cs    <= '0;
                        rd    <= 1'b0;
                        wr    <= 1'b0;
                    end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
                        cap   <= '0;
                        err   <= 1'b1;
                        state <= DONE;
                        cs    <= '0;
                        rd    <= 1'b0;
                        wr    <= 1'b0;
                    end
                end
                DONE: begin
                    // the request flags are still those of the finished instruction
                    err   <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_io_bridge.sv
// Scoreboard bench for mem_io_bridge: directed memory and IO accesses with hand-computed results.
module tb_mem_io_bridge;
    logic clock;
    logic reset;

    mem_io_bridge_if bus ();

    mem_io_bridge dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [31:0] rw;
        logic        err;
        int          len;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;
    int   run    = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h", name, act, exp);
        end
    endtask

    // Completion monitor: a stall run ending with the bridge out of reset is one finished IO access.
    always @(negedge clock) begin
        exp_t e;
        if (!reset) begin
            run = 0;
        end else if (bus.stall) begin
            run++;
        end else if (run > 0) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_completion actual=%0d expected=none", run);
            end else begin
                e = exp_q.pop_front();
                chk("done_r_wdata", bus.r_wdata, e.rw);
                chk("done_io_err", {31'b0, bus.io_err}, {31'b0, e.err});
                chk("stall_cycles", run, e.len);
            end
            run = 0;
        end
    end

    task automatic io_op(input bit rd, input logic [31:0] addr, input logic [31:0] store,
                         input int ready_at, input logic [3:0] rdy_ch, input logic [3:0] noise,
                         input logic [3:0] exp_cs, input int exp_strobe, input logic [31:0] exp_rw,
                         input bit exp_err, input bit also_mem, input string tag);
        int cs_cyc = 0;
        int cs_bad = 0;
        int rd_cyc = 0;
        int wr_cyc = 0;
        int we_cyc = 0;
        bit done   = 1'b0;
        exp_q.push_back('{exp_rw, exp_err, exp_strobe + 1});
        bus.ioRead  = rd;
        bus.ioWrite = !rd;
        bus.addr_in = addr;
        bus.r_rdata = store;
        bus.mRead   = also_mem;
        bus.mWrite  = also_mem;
        for (int c = 0; c < 40 && !done; c++) begin
            bus.io_ready = noise | ((ready_at >= 0 && c - 1 == ready_at) ? rdy_ch : 4'b0000);
            @(negedge clock);
            if (bus.stall) begin
                if (bus.io_cs != 4'b0000) cs_cyc++;
                if (bus.io_cs != 4'b0000 && bus.io_cs !== exp_cs) cs_bad++;
                rd_cyc += int'(bus.io_rd);
                wr_cyc += int'(bus.io_wr);
                we_cyc += int'(bus.mem_we);
            end else begin
                done = 1'b1;
            end
            if (!done) begin
                @(posedge clock);
                #1;
            end
        end
        chk({tag, "_completed"}, {31'b0, done}, 32'd1);
        chk({tag, "_cs_cycles"}, cs_cyc, exp_strobe);
        chk({tag, "_cs_wrong"}, cs_bad, 0);
        chk({tag, "_rd_cycles"}, rd_cyc, rd ? exp_strobe : 0);
        chk({tag, "_wr_cycles"}, wr_cyc, rd ? 0 : exp_strobe);
        chk({tag, "_mem_we"}, we_cyc, 0);
        chk({tag, "_done_cs"}, {28'b0, bus.io_cs}, 32'd0);
        chk({tag, "_io_wdata"}, {8'b0, bus.io_wdata}, {8'b0, store[23:0]});
        @(posedge clock);
        #1;
        bus.ioRead   = 1'b0;
        bus.ioWrite  = 1'b0;
        bus.mRead    = 1'b0;
        bus.mWrite   = 1'b0;
        bus.io_ready = 4'b0000;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset        = 1'b0;
        bus.mRead    = 1'b0;
        bus.mWrite   = 1'b0;
        bus.ioRead   = 1'b0;
        bus.ioWrite  = 1'b0;
        bus.addr_in  = 32'h0;
        bus.r_rdata  = 32'h0;
        bus.m_rdata  = 32'h0;
        bus.io_rdata = {24'h333333, 24'hABCDEF, 24'h111111, 24'h000001};
        bus.io_ready = 4'b0000;

        repeat (2) @(posedge clock);
        #1;
        @(negedge clock);
        chk("rst_io_cs", {28'b0, bus.io_cs}, 32'd0);
        chk("rst_strobes", {30'b0, bus.io_rd, bus.io_wr}, 32'd0);
        chk("rst_io_err", {31'b0, bus.io_err}, 32'd0);
        chk("rst_io_wdata", {8'b0, bus.io_wdata}, 32'd0);
        chk("rst_stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clock);
        #1;
        reset = 1'b1;

        bus.mWrite  = 1'b1;
        bus.addr_in = 32'h0000_0010;
        bus.r_rdata = 32'hDEAD_BEEF;
        @(negedge clock);
        chk("mem_we", {31'b0, bus.mem_we}, 32'd1);
        chk("mem_dmem", bus.data_to_dmem, 32'hDEAD_BEEF);
        chk("mem_addr_out", bus.addr_out, 32'h0000_0010);
        chk("mem_wr_stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clock);
        #1;
        bus.mWrite  = 1'b0;
        bus.mRead   = 1'b1;
        bus.addr_in = 32'h0000_0020;
        bus.m_rdata = 32'h1357_2468;
        @(negedge clock);
        chk("mem_rd_data", bus.r_wdata, 32'h1357_2468);
        chk("mem_rd_we", {31'b0, bus.mem_we}, 32'd0);
        chk("mem_rd_stall", {31'b0, bus.stall}, 32'd0);
        @(posedge clock);
        #1;
        bus.mRead = 1'b0;
        @(negedge clock);
        chk("idle_r_wdata", bus.r_wdata, 32'd0);
        @(posedge clock);
        #1;

        io_op(1'b1, 32'hFFFF_FC20, 32'h0000_0000, 0, 4'b0100, 4'b1011, 4'b0100, 1,
              32'h00AB_CDEF, 1'b0, 1'b0, "rd_ch2");
        io_op(1'b0, 32'hFFFF_FC10, 32'h1234_5678, 2, 4'b0010, 4'b0000, 4'b0010, 3,
              32'h0, 1'b0, 1'b1, "wr_ch1");
        io_op(1'b1, 32'hFFFF_FC30, 32'h55AA_55AA, -1, 4'b1000, 4'b0111, 4'b1000, 15,
              32'h0, 1'b1, 1'b0, "rd_timeout");
        io_op(1'b1, 32'hFFFF_FC40, 32'h0F0F_0F0F, -1, 4'b0000, 4'b1111, 4'b0000, 0,
              32'h0, 1'b1, 1'b0, "rd_unmapped");

        // reset while an IO write sits in WAIT
        bus.ioWrite  = 1'b1;
        bus.addr_in  = 32'hFFFF_FC00;
        bus.r_rdata  = 32'h00AB_C123;
        bus.io_ready = 4'b0000;
        repeat (3) @(posedge clock);
        #1;
        @(negedge clock);
        chk("midwait_io_wr", {31'b0, bus.io_wr}, 32'd1);
        reset       = 1'b0;
        bus.ioWrite = 1'b0;
        @(posedge clock);
        #1;
        reset = 1'b1;
        @(negedge clock);
        chk("midrst_io_cs", {28'b0, bus.io_cs}, 32'd0);
        chk("midrst_stall", {31'b0, bus.stall}, 32'd0);
        chk("midrst_io_err", {31'b0, bus.io_err}, 32'd0);
        chk("midrst_io_wr", {31'b0, bus.io_wr}, 32'd0);
        chk("midrst_io_wdata", {8'b0, bus.io_wdata}, 32'd0);
        @(posedge clock);
        #1;

        io_op(1'b1, 32'hFFFF_FC20, 32'h0000_0000, 0, 4'b0100, 4'b0000, 4'b0100, 1,
              32'h00AB_CDEF, 1'b0, 1'b0, "rd_after_rst");

        repeat (2) @(posedge clock);
        #1;
        chk("scoreboard_empty", exp_q.size(), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
